// File: rtl/pid_param.sv
// Parametrised steering PID: saturated error -> P/I/D terms -> clamped sum -> differential
// left/right speeds around the forward command, through a registered 2-stage pipeline.
module pid_param #(
    parameter int ERR_W     = 12,
    parameter int SAT_W     = 10,
    parameter int I_W       = 15,
    parameter int I_SHIFT   = 6,
    parameter int D_DLY     = 2,
    parameter int D_SAT_W   = 7,
    parameter int G_W       = 4,
    parameter int PID_W     = 14,
    parameter int PID_SHIFT = 3,
    parameter int FRWRD_W   = 10,
    parameter int SPD_W     = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               moving,
    input  logic               err_vld,
    input  logic [ERR_W-1:0]   error,
    input  logic [FRWRD_W-1:0] frwrd,
    input  logic [G_W-1:0]     kp,
    input  logic [G_W-1:0]     kd,
    input  logic               i_en,
    output logic [SPD_W-1:0]   lft_spd,
    output logic [SPD_W-1:0]   rght_spd,
    output logic               spd_vld,
    output logic               i_sat
);

    localparam int P_W    = SAT_W + G_W;
    localparam int IS_W   = I_W + 1;
    localparam int DIFF_W = SAT_W + 1;
    localparam int D_W    = D_SAT_W + G_W;
    localparam int SUM_W  = PID_W + 2;
    localparam int MIX_W  = SPD_W + 1;

    localparam logic signed [ERR_W-1:0]  ERR_MAX = {{(ERR_W-SAT_W+1){1'b0}}, {(SAT_W-1){1'b1}}};
    localparam logic signed [ERR_W-1:0]  ERR_MIN = {{(ERR_W-SAT_W+1){1'b1}}, {(SAT_W-1){1'b0}}};
    localparam logic signed [IS_W-1:0]   I_MAX   = {2'b00, {(I_W-1){1'b1}}};
    localparam logic signed [IS_W-1:0]   I_MIN   = {2'b11, {(I_W-1){1'b0}}};
    localparam logic signed [DIFF_W-1:0] D_MAX   = {{(DIFF_W-D_SAT_W+1){1'b0}}, {(D_SAT_W-1){1'b1}}};
    localparam logic signed [DIFF_W-1:0] D_MIN   = {{(DIFF_W-D_SAT_W+1){1'b1}}, {(D_SAT_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]  PID_MAX = {{(SUM_W-PID_W+1){1'b0}}, {(PID_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0]  PID_MIN = {{(SUM_W-PID_W+1){1'b1}}, {(PID_W-1){1'b0}}};
    localparam logic signed [MIX_W-1:0]  SPD_MAX = {{(MIX_W-SPD_W+1){1'b0}}, {(SPD_W-1){1'b1}}};
    localparam logic signed [MIX_W-1:0]  SPD_MIN = {{(MIX_W-SPD_W+1){1'b1}}, {(SPD_W-1){1'b0}}};

    function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [MIX_W-1:0] v);
        logic signed [SPD_W-1:0] r;
        if (v > SPD_MAX) begin
            r = SPD_MAX[SPD_W-1:0];
        end else if (v < SPD_MIN) begin
            r = SPD_MIN[SPD_W-1:0];
        end else begin
            r = v[SPD_W-1:0];
        end
        return r;
    endfunction

    logic signed [SAT_W-1:0]   err_sat_s;
    logic signed [P_W-1:0]     p_s, p_r;
    logic signed [IS_W-1:0]    i_sum_s;
    logic signed [I_W-1:0]     i_next_s, integ_r;
    logic                      i_sat_r;
    logic signed [SAT_W-1:0]   hist_r [D_DLY];
    logic signed [DIFF_W-1:0]  d_diff_s;
    logic signed [D_SAT_W-1:0] d_sat_s;
    logic signed [D_W-1:0]     d_s, d_r;
    logic                      s1_vld_r;
    logic signed [SUM_W-1:0]   i_ext_s, sum_s;
    logic signed [PID_W-1:0]   sum_sat_s;
    logic signed [MIX_W-1:0]   adj_s, frwrd_ext_s;
    logic signed [SPD_W-1:0]   lft_r, rght_r;
    logic                      spd_vld_r;

    // Stage-1 arithmetic: error clamp, P product, clamped integrator step, D difference
    always_comb begin
        if ($signed(error) > ERR_MAX) begin
            err_sat_s = ERR_MAX[SAT_W-1:0];
        end else if ($signed(error) < ERR_MIN) begin
            err_sat_s = ERR_MIN[SAT_W-1:0];
        end else begin
            err_sat_s = error[SAT_W-1:0];
        end

        p_s = P_W'(err_sat_s) * P_W'($signed({1'b0, kp}));

        i_sum_s = IS_W'(integ_r) + IS_W'(err_sat_s);
        if (i_sum_s > I_MAX) begin
            i_next_s = I_MAX[I_W-1:0];
        end else if (i_sum_s < I_MIN) begin
            i_next_s = I_MIN[I_W-1:0];
        end else begin
            i_next_s = i_sum_s[I_W-1:0];
        end

        d_diff_s = DIFF_W'(err_sat_s) - DIFF_W'(hist_r[D_DLY-1]);
        if (d_diff_s > D_MAX) begin
            d_sat_s = D_MAX[D_SAT_W-1:0];
        end else if (d_diff_s < D_MIN) begin
            d_sat_s = D_MIN[D_SAT_W-1:0];
        end else begin
            d_sat_s = d_diff_s[D_SAT_W-1:0];
        end

        d_s = D_W'(d_sat_s) * D_W'($signed({1'b0, kd}));
    end

    // Stage-2 arithmetic: clamped PID sum, shift, speed mix; i_en is read live here
    always_comb begin
        if (i_en) begin
            i_ext_s = SUM_W'(integ_r >>> I_SHIFT);
        end else begin
            i_ext_s = {SUM_W{1'b0}};
        end

        sum_s = SUM_W'(p_r) + i_ext_s + SUM_W'(d_r);
        if (sum_s > PID_MAX) begin
            sum_sat_s = PID_MAX[PID_W-1:0];
        end else if (sum_s < PID_MIN) begin
            sum_sat_s = PID_MIN[PID_W-1:0];
        end else begin
            sum_sat_s = sum_s[PID_W-1:0];
        end

        adj_s       = MIX_W'(sum_sat_s >>> PID_SHIFT);
        frwrd_ext_s = MIX_W'(frwrd);
    end

    // Stage-1 registers: terms, integrator, history; moving low flushes the pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r      <= {P_W{1'b0}};
            d_r      <= {D_W{1'b0}};
            integ_r  <= {I_W{1'b0}};
            i_sat_r  <= 1'b0;
            s1_vld_r <= 1'b0;
            for (int i = 0; i < D_DLY; i++) hist_r[i] <= {SAT_W{1'b0}};
        end else if (!moving) begin
            p_r      <= {P_W{1'b0}};
            d_r      <= {D_W{1'b0}};
            integ_r  <= {I_W{1'b0}};
            i_sat_r  <= 1'b0;
            s1_vld_r <= 1'b0;
            for (int i = 0; i < D_DLY; i++) hist_r[i] <= {SAT_W{1'b0}};
        end else begin
            s1_vld_r <= err_vld;
            if (err_vld) begin
                p_r       <= p_s;
                d_r       <= d_s;
                hist_r[0] <= err_sat_s;
                for (int i = 1; i < D_DLY; i++) hist_r[i] <= hist_r[i-1];
                if (i_en) begin
                    integ_r <= i_next_s;
                    i_sat_r <= (i_next_s == I_MAX[I_W-1:0]) || (i_next_s == I_MIN[I_W-1:0]);
                end else begin
                    integ_r <= integ_r;
                    i_sat_r <= i_sat_r;
                end
            end else begin
                p_r <= p_r;
                d_r <= d_r;
            end
        end
    end

    // Stage-2 registers: speed outputs hold between updates, strobe for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_r     <= {SPD_W{1'b0}};
            rght_r    <= {SPD_W{1'b0}};
            spd_vld_r <= 1'b0;
        end else if (!moving) begin
            lft_r     <= {SPD_W{1'b0}};
            rght_r    <= {SPD_W{1'b0}};
            spd_vld_r <= 1'b0;
        end else begin
            spd_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                lft_r  <= sat_spd(frwrd_ext_s + adj_s);
                rght_r <= sat_spd(frwrd_ext_s - adj_s);
            end else begin
                lft_r  <= lft_r;
                rght_r <= rght_r;
            end
        end
    end

    assign lft_spd  = lft_r;
    assign rght_spd = rght_r;
    assign spd_vld  = spd_vld_r;
    assign i_sat    = i_sat_r;

endmodule

// File: tb/tb_pid_param.sv
// Directed bench for pid_param: a per-cycle vector table plus hand-written
// sequences for integrator clamping and mid-flight aborts.
module tb_pid_param;

    logic        clk;
    logic        rst;
    logic        moving;
    logic        err_vld;
    logic [11:0] error;
    logic [9:0]  frwrd;
    logic [3:0]  kp;
    logic [3:0]  kd;
    logic        i_en;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        spd_vld;
    logic        i_sat;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        mv;
        logic        vld;
        logic [11:0] err;
        logic [9:0]  fw;
        logic [3:0]  p;
        logic [3:0]  d;
        logic        ie;
        logic [10:0] lft;
        logic [10:0] rgt;
        logic        sv;
        logic        isat;
    } vec_t;

    vec_t vecs [18];

    pid_param dut (
        .clk      (clk),
        .rst      (rst),
        .moving   (moving),
        .err_vld  (err_vld),
        .error    (error),
        .frwrd    (frwrd),
        .kp       (kp),
        .kd       (kd),
        .i_en     (i_en),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .spd_vld  (spd_vld),
        .i_sat    (i_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [10:0] l, input logic [10:0] r,
                           input logic sv, input logic isat);
        chk({tag, "_lft"},  32'(lft_spd),  32'(l));
        chk({tag, "_rght"}, 32'(rght_spd), 32'(r));
        chk({tag, "_vld"},  32'(spd_vld),  32'(sv));
        chk({tag, "_isat"}, 32'(i_sat),    32'(isat));
    endtask

    task automatic drive(input logic mv, input logic vld, input logic [11:0] err,
                         input logic [9:0] fw, input logic [3:0] p, input logic [3:0] d,
                         input logic ie);
        moving  = mv;
        err_vld = vld;
        error   = err;
        frwrd   = fw;
        kp      = p;
        kd      = d;
        i_en    = ie;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // P+I basic, then positive and negative saturation
        vecs[0]  = '{1'b1, 1'b0, 12'd0,    10'd256, 4'd8, 4'd0,  1'b1, 11'd0,    11'd0,    1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 12'd100,  10'd256, 4'd8, 4'd0,  1'b1, 11'd0,    11'd0,    1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 12'd0,    10'd256, 4'd8, 4'd0,  1'b1, 11'd356,  11'd156,  1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 12'd0,    10'd256, 4'd8, 4'd0,  1'b1, 11'd356,  11'd156,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 12'd0,    10'd256, 4'd8, 4'd0,  1'b1, 11'd0,    11'd0,    1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 12'h7FF,  10'd700, 4'd8, 4'd0,  1'b1, 11'd0,    11'd0,    1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 12'd0,    10'd700, 4'd8, 4'd0,  1'b1, 11'd1023, 11'd189,  1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 12'd100,  10'd700, 4'd8, 4'd0,  1'b1, 11'd0,    11'd0,    1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 12'h800,  10'd700, 4'd8, 4'd0,  1'b1, 11'd0,    11'd0,    1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 12'd0,    10'd700, 4'd8, 4'd0,  1'b1, 11'd187,  11'd1023, 1'b1, 1'b0};
        // D term through the 2-deep history, including D-difference clamping
        vecs[10] = '{1'b0, 1'b0, 12'd0,    10'd0,   4'd0, 4'd11, 1'b0, 11'd0,    11'd0,    1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 12'd0,    10'd0,   4'd0, 4'd11, 1'b0, 11'd0,    11'd0,    1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 12'd0,    10'd0,   4'd0, 4'd11, 1'b0, 11'd0,    11'd0,    1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 12'd40,   10'd0,   4'd0, 4'd11, 1'b0, 11'd0,    11'd0,    1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 12'd0,    10'd0,   4'd0, 4'd11, 1'b0, 11'd55,   11'h7C9,  1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 12'hF9C,  10'd0,   4'd0, 4'd11, 1'b0, 11'd55,   11'h7C9,  1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 12'hFEC,  10'd0,   4'd0, 4'd11, 1'b0, 11'h7A8,  11'd88,   1'b1, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 12'd0,    10'd0,   4'd0, 4'd11, 1'b0, 11'h7AD,  11'd83,   1'b1, 1'b0};

        // Reset with random inputs, then quiet release
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'($urandom), 1'($urandom), 12'($urandom), 10'($urandom),
                  4'($urandom), 4'($urandom), 1'($urandom));
            tick();
            chk_out($sformatf("reset%0d", k), 11'd0, 11'd0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 12'd0, 10'd256, 4'd8, 4'd0, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_out($sformatf("postrst%0d", k), 11'd0, 11'd0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].mv, vecs[i].vld, vecs[i].err, vecs[i].fw, vecs[i].p, vecs[i].d, vecs[i].ie);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].lft, vecs[i].rgt, vecs[i].sv, vecs[i].isat);
        end

        // Integrator clamp with back-to-back samples of 511
        drive(1'b0, 1'b0, 12'd0, 10'd0, 4'd0, 4'd0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 12'd511, 10'd0, 4'd0, 4'd0, 1'b1);
        for (int k = 0; k < 32; k++) begin
            tick();
            chk($sformatf("clamp_isat%0d", k), 32'(i_sat), 32'd0);
            if (k >= 1) chk($sformatf("clamp_vld%0d", k), 32'(spd_vld), 32'd1);
        end
        chk_out("clamp32", 11'd30, 11'h7E2, 1'b1, 1'b0);
        tick();
        chk_out("clamp33", 11'd31, 11'h7E1, 1'b1, 1'b1);
        tick();
        chk_out("clamp34", 11'd31, 11'h7E1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 12'd0, 10'd0, 4'd0, 4'd0, 1'b1);
        tick();
        chk_out("clamp_stop", 11'd0, 11'd0, 1'b0, 1'b0);

        // Abort by dropping moving with a sample in flight
        drive(1'b1, 1'b1, 12'd100, 10'd256, 4'd8, 4'd0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 12'd0, 10'd256, 4'd8, 4'd0, 1'b1);
        tick();
        chk_out("mvab_pre", 11'd356, 11'd156, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 12'd100, 10'd256, 4'd8, 4'd0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 12'd0, 10'd256, 4'd8, 4'd0, 1'b1);
        tick();
        chk_out("mvab_drop", 11'd0, 11'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 12'd0, 10'd256, 4'd8, 4'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_out($sformatf("mvab_after%0d", k), 11'd0, 11'd0, 1'b0, 1'b0);
        end

        // Abort by asynchronous reset with a sample in flight
        drive(1'b1, 1'b1, 12'd100, 10'd256, 4'd8, 4'd0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 12'd0, 10'd256, 4'd8, 4'd0, 1'b1);
        tick();
        chk_out("rstab_pre", 11'd356, 11'd156, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 12'd100, 10'd256, 4'd8, 4'd0, 1'b1);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 12'd0, 10'd256, 4'd8, 4'd0, 1'b1);
        #2;
        chk_out("rstab_async", 11'd0, 11'd0, 1'b0, 1'b0);
        tick();
        chk_out("rstab_held", 11'd0, 11'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_out($sformatf("rstab_after%0d", k), 11'd0, 11'd0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pid_param.md
# pid_param

Parametrised second-generation steering PID controller. It turns a signed heading error into differential left/right motor speeds around a forward speed command. Compared with the fixed PID it adds:
- runtime-programmable P and D gains and an I-term enable;
- a configurable D-term history depth;
- a clamping (rather than freezing) integrator with a status flag;
- PID-sum saturation;
- a registered 2-stage pipeline with an output-valid strobe.

It sits between the heading-error source and the motor PWM drivers.

## Interface
- ERR_W, 12, raw error width (signed)
- SAT_W, 10, saturated error width (signed); requires ERR_W > SAT_W
- I_W, 15, integrator width (signed)
- I_SHIFT, 6, integrator right-shift giving I_term (I_W-I_SHIFT bits)
- D_DLY, 2, err_vld samples between current and compared error (≥1)
- D_SAT_W, 7, saturated D difference width (signed)
- G_W, 4, gain width (unsigned)
- PID_W, 14, PID sum width (signed)
- PID_SHIFT, 3, arithmetic right-shift of PID sum before speed mix
- FRWRD_W, 10, forward command width (unsigned)
- SPD_W, 11, speed output width (signed)
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- moving  in  1  controller enable; low clears state
- err_vld  in  1  error sample strobe
- error  in  ERR_W  signed heading error
- frwrd  in  FRWRD_W  unsigned forward speed
- kp  in  G_W  P gain; sampled on accepted err_vld
- kd  in  G_W  D gain; sampled on accepted err_vld
- i_en  in  1  I-term enable. When low, the integrator is held and I_term contributes 0.
- lft_spd  out  SPD_W  signed left speed, registered
- rght_spd  out  SPD_W  signed right speed, registered
- spd_vld  out  1  one-cycle pulse when speeds update
- i_sat  out  1  integrator currently at a clamp limit

## Operation
- Sample acceptance: a sample is accepted when err_vld & moving.

**Error saturation** (combinational): err_sat = error clamped to the signed SAT_W range [-2^(SAT_W-1), 2^(SAT_W-1)-1].

**Stage 1** (registered on an accepted sample):
- P = err_sat × kp, signed × unsigned, at full width.
- Integrator update, when i_en:
  - integrator ← integrator + sext(err_sat);
  - the result is clamped to [-2^(I_W-1), 2^(I_W-1)-1], never wrapping;
  - i_sat = integrator equals either limit.
- History: a D_DLY-deep shift register of err_sat, advanced on every accepted sample.
- D_diff = err_sat − hist[D_DLY-1], clamped to the signed D_SAT_W range.
- D = D_diff_sat × kd.
- s1_vld ← 1.

**Stage 2** (registered when s1_vld):
- sum = P + (i_en ? integrator>>>I_SHIFT : 0) + D.
  - Computed at PID_W+2 bits.
  - Clamped to the signed PID_W range.
- adj = sum >>> PID_SHIFT.
- lft = zext(frwrd) + adj and rght = zext(frwrd) − adj.
  - Both computed at SPD_W+1 bits.
  - Both clamped to the signed SPD_W range.
- spd_vld ← 1 for one cycle.
- Between updates, lft_spd and rght_spd hold their values.

**moving low**, effective at the next clk edge:
- integrator, history, s1_vld, lft_spd, rght_spd, spd_vld and i_sat all ← 0;
- err_vld is ignored while moving is low.

**rst**: asynchronously clears every register. All outputs reset to 0.

## Timing
- Accepted sample in cycle N → stage-1 registers are updated at the end of N → outputs are updated and spd_vld is high in cycle N+2.
- Fixed latency of 2; no backpressure.
- Back-to-back err_vld every cycle is supported; each sample produces exactly one spd_vld pulse, in order.
- kp, kd and i_en are captured in the accepting cycle. Later changes do not affect in-flight samples.
  - Exception: i_en is also re-read in stage 2 for the I contribution, so it must be stable for 2 cycles.
- If moving drops between acceptance and output, the in-flight sample is discarded: no spd_vld, and the outputs read 0.
- If rst asserts mid-pipeline, the in-flight sample is discarded and spd_vld never pulses for it.
- i_sat is registered with the integrator and updates in the same cycle as the integrator.

## Test plan
1. **Reset:** assert rst with random inputs → lft_spd=0, rght_spd=0, spd_vld=0, i_sat=0; outputs stay 0 after release until the first accepted sample.
2. **P+I basic** (defaults; kp=8, kd=0, i_en=1, frwrd=256, moving=1): one err_vld with error=100 → P=800, integrator=100, I_term=1, sum=801, adj=100; two cycles later lft_spd=356, rght_spd=156, spd_vld pulse.
3. **Error and speed saturation** (kp=8, kd=0, i_en=1, frwrd=700): error=12'h7FF gives err_sat=511 → sum=4088+7=4095, adj=511; lft_spd=1023 (clamped), rght_spd=189.
4. **Integrator clamp** (error=511 every cycle, kp=kd=0):
   - after 32 samples, integrator=16352 and i_sat=0;
   - the 33rd sample clamps the integrator to 16383 and sets i_sat=1;
   - dropping moving clears the integrator, i_sat and the outputs on the next edge.
5. **D term** (kp=0, i_en=0, kd=11, frwrd=0): errors 0, 0, 40 → D_diff=40, D=440, adj=55 → lft_spd=55, rght_spd=−55 (11'h7C9).
6. **Mid-flight abort:** accept a sample, then assert rst (or drop moving) one cycle later → no spd_vld pulse and the outputs read 0.
